core_skew_feeder: RTL and testbench

//  Input staging for the systolic PE array: buffers activation row vectors
//  and weight column vectors, then streams a tile of LEN k-steps with

---
 rtl/core_skew_feeder.sv | 200 ++++++++++++++++++++
 tb/tb_core_skew_feeder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_skew_feeder.sv
// core_skew_feeder
//   Input staging for the systolic PE array. Buffers {activation, weight} vector
//   pairs in a FIFO, then streams a tile of len k-steps to the array edge. When
//   skew is enabled, lane i is delayed i extra cycles and zero-padded.
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    host write handshake for a_in/w_in (one k-step pair)
//   a_in, w_in           packed lane vectors, lane i at [i*INWIDTH +: INWIDTH]
//   start, len, skew_en  tile request; len and skew_en are sampled with start
//   level, busy          FIFO occupancy, FSM not idle
//   out_valid            a_out/w_out drive the array this cycle
//   a_out, w_out         skewed lane outputs (zero when out_valid is low)
//   done, start_err      single-cycle pulses: tile finished, start rejected
module core_skew_feeder #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned COLS    = 8,
  parameter int unsigned INWIDTH = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned LW      = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*INWIDTH-1:0] a_in,
  input  logic [COLS*INWIDTH-1:0] w_in,
  input  logic                    start,
  input  logic [LW-1:0]           len,
  input  logic                    skew_en,
  output logic [LW-1:0]           level,
  output logic                    busy,
  output logic                    out_valid,
  output logic [ROWS*INWIDTH-1:0] a_out,
  output logic [COLS*INWIDTH-1:0] w_out,
  output logic                    done,
  output logic                    start_err
);

  localparam int unsigned MAXD  = (ROWS > COLS) ? ROWS : COLS;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned AWID  = ROWS * INWIDTH;
  localparam int unsigned WWID  = COLS * INWIDTH;
  localparam int unsigned EW    = AWID + WWID;
  localparam int unsigned FW    = (MAXD > 2) ? $clog2(MAXD) : 1;
  localparam logic [FW-1:0] FLAST = FW'((MAXD > 1) ? MAXD - 2 : 0);
  localparam bit    SKEWABLE = (MAXD > 1);

  typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

  state_e          state_q;
  logic [LW-1:0]   k_q, len_q;
  logic [FW-1:0]   f_q;
  logic            skew_q, done_q, start_err_q, out_valid_q;

  // FIFO
  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            in_ready_q;
  logic            push, pop;
  logic [EW-1:0]   pop_data;
  logic [AWID-1:0] pop_a;
  logic [WWID-1:0] pop_w;

  assign push     = in_valid & in_ready_q;
  // Entry into StStream guarantees level >= len, so popping never underflows.
  assign pop      = (state_q == StStream);
  assign pop_data = mem_q[rd_ptr_q];
  // Lane inputs carry zero whenever nothing is popped; this drives the flush.
  assign pop_a    = pop ? pop_data[EW-1 -: AWID] : '0;
  assign pop_w    = pop ? pop_data[WWID-1:0] : '0;

  always_comb begin
    level_d = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {a_in, w_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_q + AW'(push);
      rd_ptr_q   <= rd_ptr_q + AW'(pop);
      level_q    <= level_d;
      in_ready_q <= (level_d != LW'(DEPTH));
    end
  end

  // Tile control
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      f_q         <= '0;
      len_q       <= '0;
      skew_q      <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      // Output registers lag the FSM by one cycle, so valid tracks the prior state.
      out_valid_q <= (state_q != StIdle);
      case (state_q)
        StIdle: begin
          if (start) begin
            if ((len != '0) && (level_q >= len)) begin
              len_q   <= len;
              skew_q  <= skew_en;
              k_q     <= '0;
              state_q <= StStream;
            end else begin
              start_err_q <= 1'b1;
            end
          end
        end
        StStream: begin
          k_q <= k_q + LW'(1);
          if (k_q == len_q - LW'(1)) begin
            f_q <= '0;
            if (skew_q && SKEWABLE) begin
              state_q <= StFlush;
            end else begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end
        StFlush: begin
          f_q <= f_q + FW'(1);
          if (f_q == FLAST) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Lane delay lines: stage 0 is the output register shared by both modes.
  // Deeper stages shift only while skewing and are zero-filled otherwise, so a
  // skewed tile following an aligned one never sees stale data.
  for (genvar i = 0; i < ROWS; i++) begin : g_a_lane
    if (i == 0) begin : g_l0
      logic [INWIDTH-1:0] sr_q;
      always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= pop_a[INWIDTH-1:0];
      end
      assign a_out[INWIDTH-1:0] = sr_q;
    end else begin : g_ln
      logic [(i+1)*INWIDTH-1:0] sr_q;
      always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= {(skew_q ? sr_q[i*INWIDTH-1:0] : {(i*INWIDTH){1'b0}}),
                          pop_a[i*INWIDTH +: INWIDTH]};
      end
      assign a_out[i*INWIDTH +: INWIDTH] = skew_q ? sr_q[(i+1)*INWIDTH-1 -: INWIDTH]
                                                  : sr_q[INWIDTH-1:0];
    end
  end

  for (genvar i = 0; i < COLS; i++) begin : g_w_lane
    if (i == 0) begin : g_l0
      logic [INWIDTH-1:0] sr_q;
      always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= pop_w[INWIDTH-1:0];
      end
      assign w_out[INWIDTH-1:0] = sr_q;
    end else begin : g_ln
      logic [(i+1)*INWIDTH-1:0] sr_q;
      always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= {(skew_q ? sr_q[i*INWIDTH-1:0] : {(i*INWIDTH){1'b0}}),
                          pop_w[i*INWIDTH +: INWIDTH]};
      end
      assign w_out[i*INWIDTH +: INWIDTH] = skew_q ? sr_q[(i+1)*INWIDTH-1 -: INWIDTH]
                                                  : sr_q[INWIDTH-1:0];
    end
  end

  assign in_ready  = in_ready_q;
  assign level     = level_q;
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign start_err = start_err_q;

endmodule

// File: tb/tb_core_skew_feeder.sv
module tb_core_skew_feeder;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = 5;
  localparam int unsigned MAXD  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   a_in = '0;
  logic [31:0]   w_in = '0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          skew_en = 1'b0;
  logic [LW-1:0] level;
  logic          busy, out_valid, done, start_err;
  logic [31:0]   a_out, w_out;

  always #5 clk = ~clk;

  core_skew_feeder #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .INWIDTH (W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .w_in      (w_in),
    .start     (start),
    .len       (len),
    .skew_en   (skew_en),
    .level     (level),
    .busy      (busy),
    .out_valid (out_valid),
    .a_out     (a_out),
    .w_out     (w_out),
    .done      (done),
    .start_err (start_err)
  );

  typedef struct packed {logic [31:0] a; logic [31:0] w;} vec_t;
  typedef struct packed {logic [31:0] a; logic [31:0] w; logic done;} exp_t;

  vec_t       model_q[$];
  exp_t       exp_q[$];
  logic [7:0] lane2_log[$];
  int         tests = 0;
  int         fails = 0;
  bit         mon_en = 1'b0;
  bit         push_pend = 1'b0;
  vec_t       pend_vec;
  logic [7:0] t2_exp [6] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
  logic [7:0] t3_exp [3] = '{8'd1, 8'd2, 8'd3};

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor
  exp_t e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        lane2_log.push_back(a_out[23:16]);
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 72'd1, 72'd0);
        end else begin
          e = exp_q.pop_front();
          check("a_out", 72'(a_out), 72'(e.a));
          check("w_out", 72'(w_out), 72'(e.w));
          check("done", 72'(done), 72'(e.done));
        end
      end else begin
        check("idle_outputs", {7'd0, done, a_out, w_out}, 72'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (push_pend) begin
      model_q.push_back(pend_vec);
      push_pend = 1'b0;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  function automatic vec_t mkvec(input int k);
    vec_t v;
    for (int j = 0; j < 4; j++) begin
      v.a[j*8 +: 8] = 8'(k + 1);
      v.w[j*8 +: 8] = 8'(8'h80 + k * 4 + j);
    end
    return v;
  endfunction

  // Producer side of the handshake: only a cycle with in_ready high is a push.
  task automatic drive_push(input vec_t v);
    in_valid = 1'b1;
    a_in     = v.a;
    w_in     = v.w;
    if (in_ready) begin
      push_pend = 1'b1;
      pend_vec  = v;
    end
  endtask

  task automatic push_n(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      drive_push(mkvec(base + k));
      cyc();
    end
  endtask

  // Expected stream: lane i at output cycle t carries entry t-i (skew) or t.
  function automatic void enqueue_tile(input int l, input bit sk);
    vec_t ent[$];
    exp_t x;
    int   n, idx;
    for (int k = 0; k < l; k++) ent.push_back(model_q.pop_front());
    n = l + (sk ? MAXD - 1 : 0);
    for (int t = 0; t < n; t++) begin
      x = '0;
      for (int i = 0; i < 4; i++) begin
        idx = sk ? t - i : t;
        if (idx >= 0 && idx < l) begin
          x.a[i*8 +: 8] = ent[idx].a[i*8 +: 8];
          x.w[i*8 +: 8] = ent[idx].w[i*8 +: 8];
        end
      end
      x.done = (t == n - 1);
      exp_q.push_back(x);
    end
  endfunction

  task automatic issue_start(input int l, input bit sk, input bit enq);
    start   = 1'b1;
    len     = LW'(l);
    skew_en = sk;
    if (enq) enqueue_tile(l, sk);
  endtask

  task automatic start_check(input int l, input bit sk, input bit enq, input bit exp_err,
                             input bit exp_busy, input string name);
    issue_start(l, sk, enq);
    cyc();
    check({name, "_start_err"}, 72'(start_err), 72'(exp_err));
    check({name, "_busy"}, 72'(busy), 72'(exp_busy));
  endtask

  task automatic wait_done(input int bound, input string name);
    int c = 0;
    while (!done && c < bound) begin
      cyc();
      c++;
    end
    check({name, "_done_seen"}, 72'(done), 72'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lens [6] = '{2, 5, 1, 7, 3, 4};
    bit   skews[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int   ti, cycles;
    bit   active;
    vec_t rv;

    // Reset state
    rst = 1'b1;
    cyc();
    cyc();
    check("rst_in_ready", 72'(in_ready), 72'd1);
    check("rst_level", 72'(level), 72'd0);
    check("rst_flags", {68'd0, busy, out_valid, done, start_err}, 72'd0);
    check("rst_data", {8'd0, a_out, w_out}, 72'd0);
    rst = 1'b0;

    // 1: reset mid-stream discards the partial tile
    push_n(4, 0);
    check("t1_level", 72'(level), 72'd4);
    start_check(4, 1'b1, 1'b0, 1'b0, 1'b1, "t1");
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_q.delete();
    check("t1_level_clr", 72'(level), 72'd0);
    check("t1_busy_clr", 72'(busy), 72'd0);
    check("t1_in_ready", 72'(in_ready), 72'd1);
    check("t1_outputs", {7'd0, out_valid, a_out, w_out}, 72'd0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("t1_no_done", {70'd0, out_valid, done}, 72'd0);
    end

    mon_en = 1'b1;

    // 2: skewed tile, len 3
    push_n(3, 0);
    lane2_log.delete();
    start_check(3, 1'b1, 1'b1, 1'b0, 1'b1, "t2");
    wait_done(30, "t2");
    cyc();
    check("t2_valid_cycles", 72'(lane2_log.size()), 72'd6);
    for (int i = 0; i < 6; i++)
      if (i < lane2_log.size()) check("t2_lane2", 72'(lane2_log[i]), 72'(t2_exp[i]));

    // 3: same data, aligned
    push_n(3, 0);
    lane2_log.delete();
    start_check(3, 1'b0, 1'b1, 1'b0, 1'b1, "t3");
    wait_done(30, "t3");
    cyc();
    check("t3_valid_cycles", 72'(lane2_log.size()), 72'd3);
    for (int i = 0; i < 3; i++)
      if (i < lane2_log.size()) check("t3_lane2", 72'(lane2_log[i]), 72'(t3_exp[i]));

    // 4: full FIFO, dropped push, push+pop in the same cycle
    push_n(16, 10);
    check("t4_full_ready", 72'(in_ready), 72'd0);
    check("t4_full_level", 72'(level), 72'd16);
    drive_push(mkvec(99));
    cyc();
    check("t4_drop_level", 72'(level), 72'd16);
    start_check(8, 1'b0, 1'b1, 1'b0, 1'b1, "t4");
    cyc();
    check("t4_first_pop", 72'(level), 72'd15);
    drive_push(mkvec(200));
    cyc();
    check("t4_pushpop_a", 72'(level), 72'd15);
    drive_push(mkvec(201));
    cyc();
    check("t4_pushpop_b", 72'(level), 72'd15);
    wait_done(40, "t4");
    cyc();
    check("t4_level_after", 72'(level), 72'd10);
    start_check(10, 1'b1, 1'b1, 1'b0, 1'b1, "t4_drain");
    wait_done(40, "t4_drain");
    cyc();
    check("t4_empty", 72'(level), 72'd0);
    check("t4_ready_again", 72'(in_ready), 72'd1);

    // 5: rejected and ignored starts
    push_n(3, 300);
    start_check(5, 1'b0, 1'b0, 1'b1, 1'b0, "t5_short");
    start_check(0, 1'b1, 1'b0, 1'b1, 1'b0, "t5_zero");
    start_check(3, 1'b1, 1'b1, 1'b0, 1'b1, "t5_go");
    start_check(1, 1'b0, 1'b0, 1'b0, 1'b1, "t5_busy");
    len     = LW'(7);
    skew_en = 1'b0;
    wait_done(30, "t5");
    cyc();
    check("t5_level", 72'(level), 72'd0);

    // 6: random push stalls with back-to-back tiles
    ti     = 0;
    cycles = 0;
    active = 1'b0;
    while ((ti < 6 || active) && cycles < 2000) begin
      cyc();
      cycles++;
      if (active && done) active = 1'b0;
      if (!active && ti < 6 && model_q.size() >= lens[ti]) begin
        issue_start(lens[ti], skews[ti], 1'b1);
        active = 1'b1;
        ti++;
      end
      if ($urandom_range(2) != 0) begin
        rv.a = $urandom;
        rv.w = $urandom;
        drive_push(rv);
      end
    end
    check("t6_all_tiles", {70'd0, (ti == 6), active}, 72'd2);
    repeat (3) cyc();
    check("t6_scoreboard_empty", 72'(exp_q.size()), 72'd0);
    check("t6_level", 72'(level), 72'(model_q.size()));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
